// File: rtl/mul_4_14.sv
// Sequential sign-magnitude Q-format multiplier: one magnitude bit per cycle,
// truncated result with overflow flag and a 3-cycle completion strobe.
module mul_4_14 #(
  parameter int unsigned Q = 14,
  parameter int unsigned N = 18
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  input  logic         i_start,
  output logic [N-1:0] o_product,
  output logic         o_complete,
  output logic         o_overflow,
  output logic         o_busy
);

  localparam int unsigned M  = N - 1;
  localparam int unsigned AW = 2 * M;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, mcand_q;
  logic [M-1:0]  mplier_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    hold_q;
  logic          sign_q;
  logic          load, finish;
  logic [M-1:0]  mag;
  logic          ovf;

  assign mag    = acc_q[N-2+Q:Q];
  assign ovf    = |acc_q[AW-1:N-1+Q];
  assign finish = (state_q == RUN) && (cnt_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = RUN;
        end else if (hold_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter reaches zero after the last add; the following edge registers the result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      hold_q     <= '0;
      o_product  <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (load) begin
        mcand_q  <= {{(AW-M){1'b0}}, i_multiplicand[M-1:0]};
        mplier_q <= i_multiplier[M-1:0];
        sign_q   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
        acc_q    <= '0;
        cnt_q    <= CW'(M);
      end else if (state_q == RUN && cnt_q != '0) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
      end

      if (finish) begin
        o_product  <= {sign_q & (|mag), mag};
        o_overflow <= ovf;
        hold_q     <= 2'd2;
      end else if (state_q == DONE && hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  assign o_complete = (state_q == DONE);
  assign o_busy     = (state_q == RUN);

endmodule

// File: doc/mul_4_14.md
MUL_4_14 -- requirements
Module: mul_4_14

Interface
REQ-001 Parameter Q, default 14, number of fractional bits.
REQ-002 Parameter N, default 18, total word width; bit N-1 is sign, bits N-2:0 are magnitude (sign-magnitude).
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_multiplicand  input  N  sign-magnitude Q-format operand A.
REQ-006 i_multiplier  input  N  sign-magnitude Q-format operand B.
REQ-007 i_start  input  1  request; sampled only when not busy.
REQ-008 o_product  output  N  sign-magnitude Q-format result, held until next completion.
REQ-009 o_complete  output  1  result-valid strobe, stretched to 3 cycles.
REQ-010 o_overflow  output  1  magnitude exceeded N-1 bits; valid with o_complete, held with o_product.
REQ-011 o_busy  output  1  high while an operation is in progress.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE with i_start=1, the block SHALL latch both magnitudes, latch sign = A[N-1]^B[N-1], clear the 2*(N-1)-bit accumulator, load the iteration counter with N-1, drop o_complete and enter RUN.
REQ-014 In RUN, each cycle SHALL examine one multiplier magnitude bit, LSB first; if 1, add the shifted multiplicand to the accumulator; then decrement the counter.
REQ-015 After exactly N-1 RUN cycles (17 by default) the block SHALL enter DONE and register the result; o_complete SHALL rise on the edge N after the accepting edge (18 by default).
REQ-016 Result magnitude SHALL be accumulator bits [N-2+Q:Q] (truncation toward zero, no rounding).
REQ-017 o_overflow SHALL be 1 iff any accumulator bit above N-2+Q is 1; o_product magnitude is then the truncated field, not saturated.
REQ-018 o_product[N-1] SHALL be the latched sign, forced to 0 when the result magnitude is zero (no negative zero).
REQ-019 In DONE, o_complete SHALL stay high for exactly 3 cycles, then the FSM returns to IDLE with o_complete=0.
REQ-020 o_busy SHALL be 1 in RUN only; i_start in RUN SHALL be ignored with no effect on the operation in flight.
REQ-021 i_start during DONE SHALL start a new operation on that edge (REQ-013), cutting the stretch short.
REQ-022 Operand inputs SHALL be sampled only on the accepting edge; later changes SHALL not affect the result.
REQ-023 o_product and o_overflow SHALL change only on the edge entering DONE.

Reset
REQ-024 On i_rst_n=0, independent of i_clk, the block SHALL enter IDLE with o_product=0, o_complete=0, o_overflow=0, o_busy=0, accumulator and counter 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no o_complete SHALL be produced for it.
REQ-026 After reset release, the first i_start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-027 A=0x06000 (1.5), B=0x08000 (2.0), start pulse -> o_complete rises 18 cycles later, o_product=0x0C000, o_overflow=0, o_complete high 3 cycles.
REQ-028 A=0x26000 (-1.5), B=0x08000 -> o_product=0x2C000 (-3.0), o_overflow=0.
REQ-029 A=0x10000 (4.0), B=0x10000 -> o_overflow=1, o_product=0x00000.
REQ-030 A=0x00000, B=0x24000 (-1.0) -> o_product=0x00000 (sign cleared), o_overflow=0.
REQ-031 Start 1.0*1.0, toggle i_start and operands during RUN, assert i_rst_n=0 at cycle 9 -> all outputs 0 immediately, no o_complete; rerun after release yields 0x04000 at cycle 18.
REQ-032 Start a second operation in the 2nd DONE cycle -> o_complete drops next edge, o_busy=1, second result correct 18 cycles after that edge.
